// File: rtl/generador_tono_if.sv
// Request/status bundle between the free-play note FSM and the tone generator.
interface generador_tono_if;
   logic [2:0] nota;
   logic       nota_valid;
   logic       stop;
   logic       ready;
   logic       busy;
   logic       audio_out;
   logic [2:0] nota_actual;
   logic       nota_fin;

   modport master (output nota, nota_valid, stop,
                   input  ready, busy, audio_out, nota_actual, nota_fin);
   modport slave  (input  nota, nota_valid, stop,
                   output ready, busy, audio_out, nota_actual, nota_fin);
endinterface

// File: rtl/generador_tono.sv
// Plays one note code as a square wave for DUR_CYCLES, then stays silent for GAP_CYCLES,
// then pulses nota_fin; stop aborts the note and rst returns everything to idle.
module generador_tono #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned DUR_CYCLES = 12500000,
   parameter int unsigned GAP_CYCLES = 500000
) (
   input logic             clk,
   input logic             rst,
   generador_tono_if.slave bus
);
   // Do (262 Hz) has the longest half-period, so it bounds the pitch counter.
   localparam int unsigned HALF_MAX = CLK_HZ / (2 * 262);
   localparam int unsigned MAX_A    = (HALF_MAX > DUR_CYCLES) ? HALF_MAX : DUR_CYCLES;
   localparam int unsigned MAX_VAL  = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
   localparam int          CNT_W    = (MAX_VAL > 1) ? $clog2(MAX_VAL) : 1;

   localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DUR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   function automatic logic [CNT_W-1:0] half_of(input logic [2:0] n);
      case (n)
         3'd1:    half_of = CNT_W'(CLK_HZ / (2 * 262));
         3'd2:    half_of = CNT_W'(CLK_HZ / (2 * 294));
         3'd3:    half_of = CNT_W'(CLK_HZ / (2 * 330));
         3'd4:    half_of = CNT_W'(CLK_HZ / (2 * 349));
         3'd5:    half_of = CNT_W'(CLK_HZ / (2 * 392));
         3'd6:    half_of = CNT_W'(CLK_HZ / (2 * 440));
         3'd7:    half_of = CNT_W'(CLK_HZ / (2 * 494));
         default: half_of = '0;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic             audio_q, audio_d;
   logic [2:0]       nota_q, nota_d;
   logic             fin_q, fin_d;
   logic [CNT_W-1:0] half_lim;
   logic             play_last, gap_last;

   assign half_lim  = half_of(nota_q);
   assign play_last = (cnt_q == DUR_LAST);
   assign gap_last  = (cnt_q == GAP_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         half_q  <= '0;
         audio_q <= 1'b0;
         nota_q  <= 3'd0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         audio_q <= audio_d;
         nota_q  <= nota_d;
         fin_q   <= fin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.nota_valid) state_d = S_PLAY;
         S_PLAY: begin
            if (bus.stop)          state_d = S_IDLE;
            else if (play_last)    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP:  if (bus.stop || gap_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      half_d  = half_q;
      audio_d = audio_q;
      nota_d  = nota_q;
      fin_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d   = '0;
            half_d  = '0;
            audio_d = 1'b0;
            nota_d  = bus.nota_valid ? bus.nota : 3'd0;
         end
         S_PLAY: begin
            if (bus.stop || play_last) begin
               cnt_d   = '0;
               half_d  = '0;
               audio_d = 1'b0;
               // With no gap the note completes straight out of PLAY.
               if (bus.stop || GAP_CYCLES == 0) nota_d = 3'd0;
               fin_d   = !bus.stop && (GAP_CYCLES == 0);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (nota_q != 3'd0) begin
                  if (half_q == half_lim - CNT_W'(1)) begin
                     half_d  = '0;
                     audio_d = ~audio_q;
                  end else begin
                     half_d  = half_q + CNT_W'(1);
                  end
               end
            end
         end
         S_GAP: begin
            audio_d = 1'b0;
            if (bus.stop || gap_last) begin
               cnt_d  = '0;
               nota_d = 3'd0;
               fin_d  = !bus.stop;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            half_d  = '0;
            audio_d = 1'b0;
            nota_d  = 3'd0;
         end
      endcase
   end

   always_comb begin
      bus.ready       = (state_q == S_IDLE);
      bus.busy        = (state_q != S_IDLE);
      bus.audio_out   = audio_q;
      bus.nota_actual = nota_q;
      bus.nota_fin    = fin_q;
   end
endmodule

// File: tb/tb_generador_tono.sv
// Directed bench for generador_tono: two instances (with and without gap) checked every
// cycle against a note-timeline model, plus literal expectations for each scenario.
module tb_generador_tono;
   localparam int CLK_HZ = 52400;
   localparam int DUR    = 1000;
   localparam int GAP_A  = 50;
   localparam int GAP_B  = 0;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   generador_tono_if ifa();
   generador_tono_if ifb();

   generador_tono #(.CLK_HZ(CLK_HZ), .DUR_CYCLES(DUR), .GAP_CYCLES(GAP_A)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa));
   generador_tono #(.CLK_HZ(CLK_HZ), .DUR_CYCLES(DUR), .GAP_CYCLES(GAP_B)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkv(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s {ready,busy,audio,nota_actual,fin}: got %b, expected %b (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // Note timeline model: a note occupies DUR+gap cycles from acceptance; during the
   // first DUR cycles the wave level is the parity of (elapsed / half-period).
   function automatic int half_of(input int n);
      int f;
      case (n)
         1: f = 262;
         2: f = 294;
         3: f = 330;
         4: f = 349;
         5: f = 392;
         6: f = 440;
         7: f = 494;
         default: f = 0;
      endcase
      return (f == 0) ? 0 : CLK_HZ / (2 * f);
   endfunction

   bit m_act[2];
   int m_note[2];
   int m_e[2];
   bit m_fin[2];
   bit m_live = 1'b0;

   always @(posedge clk) begin
      bit vld, stp;
      int nn, gap;
      for (int k = 0; k < 2; k++) begin
         vld = (k == 0) ? ifa.nota_valid : ifb.nota_valid;
         stp = (k == 0) ? ifa.stop : ifb.stop;
         nn  = int'((k == 0) ? ifa.nota : ifb.nota);
         gap = (k == 0) ? GAP_A : GAP_B;
         if (rst) begin
            m_act[k] = 1'b0; m_note[k] = 0; m_e[k] = 0; m_fin[k] = 1'b0;
         end else begin
            m_fin[k] = 1'b0;
            if (!m_act[k]) begin
               if (vld) begin m_act[k] = 1'b1; m_note[k] = nn; m_e[k] = 0; end
            end else if (stp) begin
               m_act[k] = 1'b0; m_note[k] = 0;
            end else if (m_e[k] == DUR + gap - 1) begin
               m_act[k] = 1'b0; m_note[k] = 0; m_fin[k] = 1'b1;
            end else begin
               m_e[k]++;
            end
         end
      end
      if (rst) m_live = 1'b1;
   end

   function automatic logic [6:0] expect_of(input int k);
      logic aud;
      aud = m_act[k] && (m_note[k] != 0) && (m_e[k] < DUR) &&
            (((m_e[k] / half_of(m_note[k])) % 2) == 1);
      return {~m_act[k], m_act[k], aud, 3'(m_note[k]), m_fin[k]};
   endfunction

   always @(negedge clk) begin
      if (m_live) begin
         chkv("dut_a outputs", {ifa.ready, ifa.busy, ifa.audio_out, ifa.nota_actual, ifa.nota_fin},
              expect_of(0));
         chkv("dut_b outputs", {ifb.ready, ifb.busy, ifb.audio_out, ifb.nota_actual, ifb.nota_fin},
              expect_of(1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_note_a(input logic [2:0] n);
      ifa.nota = n;
      ifa.nota_valid = 1'b1;
      tick();
      ifa.nota_valid = 1'b0;
      ifa.nota = 3'd0;
   endtask

   task automatic run_note_a(output int busy_c, output int rises, output int toggles);
      logic prev;
      int   guard;
      busy_c = 0; rises = 0; toggles = 0; prev = 1'b0; guard = 0;
      while (ifa.busy && guard < 5000) begin
         busy_c++;
         if (ifa.audio_out != prev) begin
            toggles++;
            if (ifa.audio_out) rises++;
         end
         prev = ifa.audio_out;
         tick();
         guard++;
      end
      chk("note ends within bound", int'(guard < 5000), 1);
   endtask

   task automatic check_completion_a(input string tag);
      chk({tag, " nota_fin at completion"}, int'(ifa.nota_fin), 1);
      chk({tag, " ready at completion"}, int'(ifa.ready), 1);
      chk({tag, " nota_actual after note"}, int'(ifa.nota_actual), 0);
      tick();
      chk({tag, " nota_fin single cycle"}, int'(ifa.nota_fin), 0);
   endtask

   task automatic check_idle_a(input string tag);
      chk({tag, " ready"}, int'(ifa.ready), 1);
      chk({tag, " busy"}, int'(ifa.busy), 0);
      chk({tag, " audio_out"}, int'(ifa.audio_out), 0);
      chk({tag, " nota_actual"}, int'(ifa.nota_actual), 0);
      chk({tag, " nota_fin"}, int'(ifa.nota_fin), 0);
   endtask

   task automatic wait_fin_b(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!ifb.nota_fin && n < 5000);
      chk("b nota_fin within bound", int'(n < 5000), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_c, rises, toggles, n;
      rst = 1'b1;
      ifa.nota = 3'd0; ifa.nota_valid = 1'b0; ifa.stop = 1'b0;
      ifb.nota = 3'd0; ifb.nota_valid = 1'b0; ifb.stop = 1'b0;
      repeat (3) tick();
      check_idle_a("reset");
      rst = 1'b0;
      tick();

      // Scenario 1: Do, half-period 100, 1000 cycles sounding, 50 silent.
      start_note_a(3'd1);
      chk("t1 ready drops", int'(ifa.ready), 0);
      chk("t1 nota_actual latched", int'(ifa.nota_actual), 1);
      run_note_a(busy_c, rises, toggles);
      chk("t1 busy cycles", busy_c, 1050);
      chk("t1 rising edges", rises, 5);
      chk("t1 toggles incl. drop into gap", toggles, 10);
      check_completion_a("t1");

      // Scenario 2: La, half-period 59 -> 16 toggles, ending low.
      start_note_a(3'd6);
      chk("t2 nota_actual latched", int'(ifa.nota_actual), 6);
      run_note_a(busy_c, rises, toggles);
      chk("t2 busy cycles", busy_c, 1050);
      chk("t2 toggles", toggles, 16);
      check_completion_a("t2");

      // Scenario 3: rest.
      start_note_a(3'd0);
      chk("t3 busy on rest", int'(ifa.busy), 1);
      run_note_a(busy_c, rises, toggles);
      chk("t3 busy cycles", busy_c, 1050);
      chk("t3 toggles", toggles, 0);
      check_completion_a("t3");

      // Scenario 4: ignored request during PLAY, then stop at 300 cycles.
      start_note_a(3'd1);
      repeat (100) tick();
      ifa.nota = 3'd3; ifa.nota_valid = 1'b1;
      tick();
      ifa.nota_valid = 1'b0; ifa.nota = 3'd0;
      chk("t4 request ignored nota_actual", int'(ifa.nota_actual), 1);
      repeat (199) tick();
      chk("t4 audio high before stop", int'(ifa.audio_out), 1);
      ifa.stop = 1'b1;
      tick();
      ifa.stop = 1'b0;
      check_idle_a("t4 after stop");
      repeat (5) tick();
      ifa.nota = 3'd5; ifa.nota_valid = 1'b1; ifa.stop = 1'b1;
      tick();
      ifa.nota_valid = 1'b0; ifa.stop = 1'b0; ifa.nota = 3'd0;
      chk("t4 stop+valid in idle accepted busy", int'(ifa.busy), 1);
      chk("t4 stop+valid in idle nota_actual", int'(ifa.nota_actual), 5);
      ifa.stop = 1'b1;
      tick();
      ifa.stop = 1'b0;
      tick();

      // Scenario 5: no gap, request held high -> back-to-back notes.
      ifb.nota = 3'd2; ifb.nota_valid = 1'b1;
      tick();
      chk("t5 first note latched", int'(ifb.nota_actual), 2);
      wait_fin_b(n);
      chk("t5 first note length", n, 1000);
      chk("t5 ready at fin", int'(ifb.ready), 1);
      chk("t5 busy at fin", int'(ifb.busy), 0);
      tick();
      chk("t5 next note started", int'(ifb.busy), 1);
      chk("t5 fin single cycle", int'(ifb.nota_fin), 0);
      chk("t5 next note code", int'(ifb.nota_actual), 2);
      wait_fin_b(n);
      chk("t5 fin to fin spacing", n, 1000);
      ifb.nota_valid = 1'b0;
      tick();
      chk("t5 idle after release", int'(ifb.busy), 0);

      // Scenario 6: reset during GAP, during a high PLAY phase, and together with a request.
      start_note_a(3'd1);
      repeat (1025) tick();
      chk("t6 in gap busy", int'(ifa.busy), 1);
      chk("t6 in gap audio", int'(ifa.audio_out), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_a("t6 rst in gap");
      start_note_a(3'd1);
      repeat (150) tick();
      chk("t6 audio high before rst", int'(ifa.audio_out), 1);
      rst = 1'b1;
      tick();
      check_idle_a("t6 rst in play");
      ifa.nota = 3'd4; ifa.nota_valid = 1'b1;
      tick();
      chk("t6 rst beats request busy", int'(ifa.busy), 0);
      chk("t6 rst beats request nota_actual", int'(ifa.nota_actual), 0);
      rst = 1'b0; ifa.nota_valid = 1'b0; ifa.nota = 3'd0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
